bcd_ex3_seq_ctrl: RTL and testbench
===================================

# bcd_ex3_seq_ctrl

Sequencer that converts a packed multi-digit BCD word to excess-3, one digit per clock, through a single shared BCD-to-excess-3 digit converter. It uses a start/busy/done handshake and flags any non-BCD digit (value > 9) per position. It sits between a register-file or host interface and the digit converter. The converter datapath is time-shared across all digit positions instead of being replicated.

## Interface
- DIGITS, 4, number of BCD digits per word (≥ 1)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- start  in  1  request a conversion; sampled only in IDLE
- bcd_in  in  4*DIGITS  packed BCD word; digit k at [4k+3:4k], digit 0 least significant
- busy  out  1  high while a conversion is in progress (CONV or DONE)
- done  out  1  one-cycle pulse; ex3_out, err and err_mask are valid and stable from this cycle
- ex3_out  out  4*DIGITS  packed excess-3 result, same digit layout as bcd_in
- err_mask  out  DIGITS  bit k set when digit k of the last word was > 9
- err  out  1  OR of err_mask

## Operation
- States:
  - IDLE: busy=0, done=0.
  - CONV: busy=1, done=0.
  - DONE: busy=1, done=1.
- IDLE → CONV when start=1:
  - Latch bcd_in into an internal word register.
  - Clear the digit index to 0.
  - Clear the internal result and internal error accumulators.
- CONV, each cycle:
  - Select digit[idx] of the latched word and pass it through the shared converter.
  - Write the converted value into slot idx of the internal result accumulator.
  - Increment idx.
  - Digits are processed LSD first.
- Conversion rule per digit d:
  - d ≤ 9: slot = d + 3, 4-bit. Range 0011..1100, no carry out.
  - d ≥ 10: slot = 4'b0000, which is an out-of-range marker for excess-3, and the err accumulator bit idx is set.
- CONV → DONE after slot DIGITS-1 is written. On that same edge, copy the internal result to ex3_out and the error accumulator to err_mask/err.
- DONE → IDLE unconditionally after one cycle.
- Outputs hold their last completed result until the next DONE or reset. Intermediate slots are never visible on ex3_out.
- start while busy=1 is ignored and is not queued.
- bcd_in changes after the start cycle have no effect on the running conversion.
- Index counter width is $clog2(DIGITS+1). DIGITS=1 must work: exactly one CONV cycle.

## Timing
- Reset values: state IDLE, busy=0, done=0, ex3_out=0, err_mask=0, err=0. The internal word register, index and accumulators are also cleared.
- rst has priority over all other inputs. Asserting rst during CONV or DONE abandons the conversion. Outputs read reset values on the cycle after the rst edge, and no done pulse is produced.
- Let T be the cycle in which start=1 is sampled in IDLE:
  - busy is high from T+1 through T+DIGITS+1.
  - Digit k is converted in cycle T+1+k.
  - done=1 in cycle T+DIGITS+1, with results valid in that same cycle.
- Return to IDLE is at T+DIGITS+2, where a new start is accepted. The back-to-back period is DIGITS+2 cycles.
- With start held high continuously, conversions repeat every DIGITS+2 cycles. Each one latches bcd_in as sampled in its own start cycle.
- done is never high for two consecutive cycles.

## Test plan
- All tests use DIGITS=4.
- Reset: hold rst for 2 cycles with random start/bcd_in → busy=0, done=0, ex3_out=16'h0000, err_mask=4'b0000, err=0.
- Basic: bcd_in=16'h1239, start pulse at T → busy high T+1..T+5, done only at T+5, ex3_out=16'h456C, err=0.
- Corners:
  - 16'h0000 → 16'h3333.
  - Then 16'h9999 → 16'hCCCC.
  - Results are stable between the two done pulses.
- Invalid digits: bcd_in=16'h1A2F → ex3_out=16'h4050, err_mask=4'b0101, err=1. A following conversion of 16'h0001 → err=0, err_mask=0, ex3_out=16'h3334.
- Handshake:
  - Hold start high and change bcd_in every cycle during CONV → each result matches the word sampled at its start cycle.
  - done pulses arrive exactly 6 cycles apart.
  - Extra start pulses while busy are ignored.
- Reset mid-operation: assert rst at T+2 of a conversion of 16'h5678 → cycle after: IDLE, outputs all zero, no done pulse. Start at the next cycle → done 5 cycles later with ex3_out=16'h89AB.

Source files
------------

// File: rtl/bcd_ex3_seq_ctrl_if.sv
// Handshake and data bundle between a host and the BCD to excess-3 sequencer.
// The host drives start/bcd_in. The sequencer returns status and the converted word.
interface bcd_ex3_seq_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   ex3_out;
  logic [DIGITS-1:0]     err_mask;
  logic                  err;

  modport master (
    output start, bcd_in,
    input  busy, done, ex3_out, err_mask, err
  );

  modport slave (
    input  start, bcd_in,
    output busy, done, ex3_out, err_mask, err
  );
endinterface

// File: rtl/bcd_ex3_seq_ctrl.sv
// Multi-digit BCD to excess-3 sequencer.
// One shared digit converter is stepped across the latched word, least significant digit first.
// The finished word, and the positions that were not valid BCD, are published together with a one-cycle done pulse.
module bcd_ex3_seq_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic               clk,
  input  logic               rst,
  bcd_ex3_seq_ctrl_if.slave  bus
);

  localparam int IDX_W = $clog2(DIGITS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [4*DIGITS-1:0]  word_q;
  logic [IDX_W-1:0]     idx_q;
  logic [4*DIGITS-1:0]  acc_q;
  logic [DIGITS-1:0]    err_acc_q;
  logic [4*DIGITS-1:0]  ex3_q;
  logic [DIGITS-1:0]    err_mask_q;

  logic [3:0]           cur_digit;
  logic [3:0]           cur_ex3;
  logic                 cur_bad;
  logic                 last_digit;
  logic [4*DIGITS-1:0]  acc_next;
  logic [DIGITS-1:0]    err_next;

  // Select the current digit and run it through the shared converter; 0000 marks a non-BCD digit.
  always_comb begin
    cur_digit = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) cur_digit = word_q[4*k +: 4];
    end
    cur_bad = (cur_digit > 4'd9);
    cur_ex3 = cur_bad ? 4'd0 : (cur_digit + 4'd3);
    last_digit = (idx_q == IDX_W'(DIGITS - 1));
  end

  // Merge the converted digit into its slot so the final slot can be published on the same edge.
  always_comb begin
    acc_next = acc_q;
    err_next = err_acc_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        acc_next[4*k +: 4] = cur_ex3;
        err_next[k]        = cur_bad;
      end
    end
  end

  // State register; reset abandons any conversion in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake outputs; start is only honoured in IDLE.
  always_comb begin
    state_next = state;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_next = CONV;
      end
      CONV: begin
        bus.busy = 1'b1;
        if (last_digit) state_next = DONE;
      end
      DONE: begin
        bus.busy   = 1'b1;
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch on accept, fill one slot per CONV cycle, publish results when the last slot lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q     <= '0;
      idx_q      <= '0;
      acc_q      <= '0;
      err_acc_q  <= '0;
      ex3_q      <= '0;
      err_mask_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            word_q    <= bus.bcd_in;
            idx_q     <= '0;
            acc_q     <= '0;
            err_acc_q <= '0;
          end
        end
        CONV: begin
          acc_q     <= acc_next;
          err_acc_q <= err_next;
          idx_q     <= idx_q + IDX_W'(1);
          if (last_digit) begin
            ex3_q      <= acc_next;
            err_mask_q <= err_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ex3_out  = ex3_q;
  assign bus.err_mask = err_mask_q;
  assign bus.err      = |err_mask_q;

endmodule

// File: tb/tb_bcd_ex3_seq_ctrl.sv
// Self-checking bench for bcd_ex3_seq_ctrl with DIGITS=4.
// Expected words come from a per-digit arithmetic model. Expected timing comes from the cycle the start request was accepted.
module tb_bcd_ex3_seq_ctrl;

  localparam int DIGITS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] last_ex3  = 16'h0000;
  logic [3:0]  last_mask = 4'h0;

  bcd_ex3_seq_ctrl_if #(.DIGITS(DIGITS)) bus ();

  bcd_ex3_seq_ctrl #(.DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Safety net so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: each digit d maps to d+3, or to 0 with its error bit set when d > 9
  function automatic void model(input logic [15:0] word, output logic [15:0] ex3, output logic [3:0] mask);
    int d;
    ex3  = 16'h0000;
    mask = 4'h0;
    for (int k = 0; k < DIGITS; k++) begin
      d = int'((word >> (4 * k)) & 16'h000F);
      if (d > 9) mask = mask | 4'(1 << k);
      else       ex3  = ex3 | 16'((d + 3) << (4 * k));
    end
  endfunction

  // Advance one clock. Inputs are driven, and outputs sampled, 1 time unit after the edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One full conversion started in the current cycle. With noise set, start and bcd_in are toggled while the sequencer is busy.
  task automatic applyStimulus(input logic [15:0] word, input bit noise);
    logic [15:0] ex3;
    logic [3:0]  mask;
    model(word, ex3, mask);
    bus.bcd_in = word;
    bus.start  = 1'b1;
    for (int c = 1; c <= DIGITS + 1; c++) begin
      stepCycle();
      bus.start = noise ? 1'($urandom) : 1'b0;
      if (noise) bus.bcd_in = 16'($urandom);
      checkOutput("busy_done", {14'd0, bus.busy, bus.done}, (c == DIGITS + 1) ? 16'd3 : 16'd2);
      if (c < DIGITS + 1) checkOutput("held_ex3", bus.ex3_out, last_ex3);
    end
    checkOutput("ex3_out", bus.ex3_out, ex3);
    checkOutput("err_mask", {12'd0, bus.err_mask}, {12'd0, mask});
    checkOutput("err", {15'd0, bus.err}, {15'd0, |mask});
    last_ex3  = ex3;
    last_mask = mask;
    bus.start = 1'b0;
    stepCycle();
    checkOutput("idle_after", {14'd0, bus.busy, bus.done}, 16'd0);
    checkOutput("ex3_hold", bus.ex3_out, ex3);
  endtask

  initial begin
    logic [15:0] words[$];
    int          due[$];
    int          next_acc;
    int          last_done;
    logic        exp_done;
    logic [15:0] w;
    logic [15:0] ex3;
    logic [3:0]  mask;

    bus.start  = 1'b0;
    bus.bcd_in = 16'h0000;

    // Reset held for two cycles with random inputs
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.start  = 1'($urandom);
      bus.bcd_in = 16'($urandom);
      stepCycle();
    end
    checkOutput("rst_busy_done", {14'd0, bus.busy, bus.done}, 16'd0);
    checkOutput("rst_ex3", bus.ex3_out, 16'h0000);
    checkOutput("rst_mask", {12'd0, bus.err_mask}, 16'd0);
    checkOutput("rst_err", {15'd0, bus.err}, 16'd0);
    rst        = 1'b0;
    bus.start  = 1'b0;
    stepCycle();

    // Basic conversion
    applyStimulus(16'h1239, 1'b0);
    checkOutput("basic_const", bus.ex3_out, 16'h456C);

    // Corners, with the held-result check covering the gap between done pulses
    applyStimulus(16'h0000, 1'b0);
    checkOutput("zero_const", bus.ex3_out, 16'h3333);
    applyStimulus(16'h9999, 1'b0);
    checkOutput("nine_const", bus.ex3_out, 16'hCCCC);

    // Invalid digits, then a clean word clears the error state
    applyStimulus(16'h1A2F, 1'b0);
    checkOutput("bad_const", bus.ex3_out, 16'h4050);
    checkOutput("bad_mask_const", {12'd0, bus.err_mask}, 16'h0005);
    applyStimulus(16'h0001, 1'b0);
    checkOutput("clean_const", bus.ex3_out, 16'h3334);
    checkOutput("clean_err", {15'd0, bus.err}, 16'd0);

    // Random words with start/bcd_in noise while busy
    for (int i = 0; i < 8; i++) applyStimulus(16'($urandom), 1'b1);

    // start held high and bcd_in changing every cycle: each accepted word is the one present at its own start cycle
    next_acc  = 0;
    last_done = -1;
    for (int cyc = 0; cyc < 24; cyc++) begin
      w          = 16'($urandom);
      bus.bcd_in = w;
      bus.start  = 1'b1;
      if (cyc == next_acc) begin
        words.push_back(w);
        due.push_back(cyc + DIGITS + 1);
        next_acc = next_acc + DIGITS + 2;
      end
      stepCycle();
      exp_done = (due.size() > 0) && (due[0] == cyc + 1);
      checkOutput("hold_done", {15'd0, bus.done}, {15'd0, exp_done});
      if (bus.done) begin
        if (last_done >= 0) checkOutput("done_period", 16'(cyc + 1 - last_done), 16'd6);
        last_done = cyc + 1;
      end
      if (exp_done) begin
        model(words.pop_front(), ex3, mask);
        void'(due.pop_front());
        checkOutput("hold_ex3", bus.ex3_out, ex3);
        checkOutput("hold_mask", {12'd0, bus.err_mask}, {12'd0, mask});
        last_ex3  = ex3;
        last_mask = mask;
      end
    end
    checkOutput("hold_count", 16'(words.size()), 16'd0);
    bus.start = 1'b0;
    stepCycle();
    checkOutput("hold_idle", {14'd0, bus.busy, bus.done}, 16'd0);

    // Reset two cycles into a conversion abandons it
    bus.bcd_in = 16'h5678;
    bus.start  = 1'b1;
    stepCycle();
    bus.start  = 1'b0;
    stepCycle();
    rst = 1'b1;
    stepCycle();
    checkOutput("midrst_busy_done", {14'd0, bus.busy, bus.done}, 16'd0);
    checkOutput("midrst_ex3", bus.ex3_out, 16'h0000);
    checkOutput("midrst_mask", {12'd0, bus.err_mask, 3'd0, bus.err}, 16'd0);
    rst = 1'b0;
    last_ex3  = 16'h0000;
    last_mask = 4'h0;
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput("midrst_no_done", {14'd0, bus.busy, bus.done}, 16'd0);
    end
    applyStimulus(16'h5678, 1'b0);
    checkOutput("midrst_const", bus.ex3_out, 16'h89AB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
